// File: rtl/mem_stage_ctrl.sv
// MEM stage: runs loads/stores against a req/ack data memory, issues NoC MMR writes,
// and hands a registered writeback bundle to WB. Upstream is stalled while an access is open.
module mem_stage_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [2:0]  mem_flag,
  input  logic [31:0] mem_addr,
  input  logic [31:0] store_data,
  input  logic [31:0] alu_result,
  input  logic [4:0]  rd_addr_in,
  input  logic        rd_we_in,
  input  logic        mmr_we_in,
  input  logic [31:0] inst_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mmr_we,
  output logic [31:0] mmr_addr,
  output logic [31:0] mmr_wdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd_addr,
  output logic        wb_rd_we,
  output logic [31:0] wb_rd_data,
  output logic [31:0] wb_inst,
  output logic        err_misalign,
  output logic        err_timeout
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  localparam logic [2:0] F_LW  = 3'b001;
  localparam logic [2:0] F_LB  = 3'b111;
  localparam logic [2:0] F_SW  = 3'b010;
  localparam logic [2:0] F_SB  = 3'b100;
  localparam logic [2:0] F_NOC = 3'b011;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
  logic [3:0]        dmem_be_q, dmem_be_d;
  logic [31:0]       dmem_addr_q, dmem_addr_d, dmem_wdata_q, dmem_wdata_d;
  logic              mmr_we_q, mmr_we_d;
  logic [31:0]       mmr_addr_q, mmr_addr_d, mmr_wdata_q, mmr_wdata_d;
  logic              wb_valid_q, wb_valid_d, wb_rd_we_q, wb_rd_we_d;
  logic [4:0]        wb_rd_addr_q, wb_rd_addr_d;
  logic [31:0]       wb_rd_data_q, wb_rd_data_d, wb_inst_q, wb_inst_d;
  logic              err_misalign_q, err_misalign_d, err_timeout_q, err_timeout_d;
  logic              hold_byte_q, hold_byte_d, hold_rd_we_q, hold_rd_we_d;
  logic [1:0]        hold_lane_q, hold_lane_d;
  logic [4:0]        hold_rd_addr_q, hold_rd_addr_d;
  logic [31:0]       hold_inst_q, hold_inst_d;
  logic [7:0]        lb_byte;
  logic              is_word, is_byte, is_store;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    cnt_inc        = cnt_q + 1'b1;
    dmem_req_d     = dmem_req_q;
    dmem_we_d      = dmem_we_q;
    dmem_be_d      = dmem_be_q;
    dmem_addr_d    = dmem_addr_q;
    dmem_wdata_d   = dmem_wdata_q;
    mmr_we_d       = 1'b0;
    mmr_addr_d     = mmr_addr_q;
    mmr_wdata_d    = mmr_wdata_q;
    wb_valid_d     = 1'b0;
    wb_rd_addr_d   = wb_rd_addr_q;
    wb_rd_we_d     = wb_rd_we_q;
    wb_rd_data_d   = wb_rd_data_q;
    wb_inst_d      = wb_inst_q;
    err_misalign_d = 1'b0;
    err_timeout_d  = 1'b0;
    hold_byte_d    = hold_byte_q;
    hold_rd_we_d   = hold_rd_we_q;
    hold_lane_d    = hold_lane_q;
    hold_rd_addr_d = hold_rd_addr_q;
    hold_inst_d    = hold_inst_q;
    is_word        = (mem_flag == F_LW) || (mem_flag == F_SW);
    is_byte        = (mem_flag == F_LB) || (mem_flag == F_SB);
    is_store       = (mem_flag == F_SW) || (mem_flag == F_SB);

    case (hold_lane_q)
      2'd0:    lb_byte = dmem_rdata[7:0];
      2'd1:    lb_byte = dmem_rdata[15:8];
      2'd2:    lb_byte = dmem_rdata[23:16];
      default: lb_byte = dmem_rdata[31:24];
    endcase

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          wb_rd_addr_d = rd_addr_in;
          wb_inst_d    = inst_in;
          if ((is_word && mem_addr[1:0] == 2'b00) || is_byte) begin
            state_d        = S_ACCESS;
            cnt_d          = '0;
            dmem_req_d     = 1'b1;
            dmem_we_d      = is_store;
            dmem_be_d      = is_byte ? (4'b0001 << mem_addr[1:0]) : 4'b1111;
            dmem_addr_d    = {mem_addr[31:2], 2'b00};
            dmem_wdata_d   = (mem_flag == F_SB) ? {4{store_data[7:0]}} : store_data;
            hold_byte_d    = is_byte;
            hold_lane_d    = mem_addr[1:0];
            hold_rd_we_d   = rd_we_in && (rd_addr_in != 5'd0);
            hold_rd_addr_d = rd_addr_in;
            hold_inst_d    = inst_in;
            wb_rd_addr_d   = wb_rd_addr_q;
            wb_inst_d      = wb_inst_q;
          end else if (is_word) begin
            err_misalign_d = 1'b1;
            wb_valid_d     = 1'b1;
            wb_rd_we_d     = 1'b0;
            wb_rd_data_d   = alu_result;
          end else if (mem_flag == F_NOC) begin
            mmr_we_d    = mmr_we_in;
            mmr_addr_d  = mem_addr;
            mmr_wdata_d = store_data;
            wb_valid_d  = 1'b1;
            wb_rd_we_d  = 1'b0;
          end else begin
            wb_valid_d   = 1'b1;
            wb_rd_we_d   = rd_we_in && (rd_addr_in != 5'd0);
            wb_rd_data_d = alu_result;
          end
        end
      end
      default: begin
        // An ack landing on the limit cycle still completes the access.
        if (dmem_ack || cnt_inc == CNT_LIMIT) begin
          state_d      = S_IDLE;
          cnt_d        = '0;
          dmem_req_d   = 1'b0;
          wb_valid_d   = 1'b1;
          wb_rd_addr_d = hold_rd_addr_q;
          wb_inst_d    = hold_inst_q;
          wb_rd_we_d   = 1'b0;
          if (!dmem_ack) begin
            err_timeout_d = 1'b1;
          end else if (!dmem_we_q) begin
            wb_rd_we_d   = hold_rd_we_q;
            wb_rd_data_d = hold_byte_q ? {{24{lb_byte[7]}}, lb_byte} : dmem_rdata;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      dmem_req_q     <= 1'b0;
      dmem_we_q      <= 1'b0;
      dmem_be_q      <= 4'b0;
      dmem_addr_q    <= 32'b0;
      dmem_wdata_q   <= 32'b0;
      mmr_we_q       <= 1'b0;
      mmr_addr_q     <= 32'b0;
      mmr_wdata_q    <= 32'b0;
      wb_valid_q     <= 1'b0;
      wb_rd_addr_q   <= 5'b0;
      wb_rd_we_q     <= 1'b0;
      wb_rd_data_q   <= 32'b0;
      wb_inst_q      <= 32'b0;
      err_misalign_q <= 1'b0;
      err_timeout_q  <= 1'b0;
      hold_byte_q    <= 1'b0;
      hold_rd_we_q   <= 1'b0;
      hold_lane_q    <= 2'b0;
      hold_rd_addr_q <= 5'b0;
      hold_inst_q    <= 32'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      dmem_req_q     <= dmem_req_d;
      dmem_we_q      <= dmem_we_d;
      dmem_be_q      <= dmem_be_d;
      dmem_addr_q    <= dmem_addr_d;
      dmem_wdata_q   <= dmem_wdata_d;
      mmr_we_q       <= mmr_we_d;
      mmr_addr_q     <= mmr_addr_d;
      mmr_wdata_q    <= mmr_wdata_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_addr_q   <= wb_rd_addr_d;
      wb_rd_we_q     <= wb_rd_we_d;
      wb_rd_data_q   <= wb_rd_data_d;
      wb_inst_q      <= wb_inst_d;
      err_misalign_q <= err_misalign_d;
      err_timeout_q  <= err_timeout_d;
      hold_byte_q    <= hold_byte_d;
      hold_rd_we_q   <= hold_rd_we_d;
      hold_lane_q    <= hold_lane_d;
      hold_rd_addr_q <= hold_rd_addr_d;
      hold_inst_q    <= hold_inst_d;
    end
  end

  assign stall_out    = (state_q == S_ACCESS);
  assign dmem_req     = dmem_req_q;
  assign dmem_we      = dmem_we_q;
  assign dmem_be      = dmem_be_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign mmr_we       = mmr_we_q;
  assign mmr_addr     = mmr_addr_q;
  assign mmr_wdata    = mmr_wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd_addr   = wb_rd_addr_q;
  assign wb_rd_we     = wb_rd_we_q;
  assign wb_rd_data   = wb_rd_data_q;
  assign wb_inst      = wb_inst_q;
  assign err_misalign = err_misalign_q;
  assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: table of single ops plus timeout/reset sequences; WB results via scoreboard.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        reset, in_valid, rd_we_in, mmr_we_in, dmem_ack;
  logic [2:0]  mem_flag;
  logic [31:0] mem_addr, store_data, alu_result, inst_in, dmem_rdata;
  logic [4:0]  rd_addr_in;
  logic        stall_out, dmem_req, dmem_we, mmr_we, wb_valid, wb_rd_we, err_misalign, err_timeout;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata, mmr_addr, mmr_wdata, wb_rd_data, wb_inst;
  logic [4:0]  wb_rd_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .mem_flag(mem_flag), .mem_addr(mem_addr),
    .store_data(store_data), .alu_result(alu_result), .rd_addr_in(rd_addr_in), .rd_we_in(rd_we_in),
    .mmr_we_in(mmr_we_in), .inst_in(inst_in), .stall_out(stall_out), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .mmr_we(mmr_we), .mmr_addr(mmr_addr),
    .mmr_wdata(mmr_wdata), .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_rd_we(wb_rd_we),
    .wb_rd_data(wb_rd_data), .wb_inst(wb_inst), .err_misalign(err_misalign), .err_timeout(err_timeout)
  );

  typedef struct {
    logic [2:0]  flag;
    logic [31:0] addr, sdata, alu, rdata;
    logic [4:0]  rd;
    logic        rd_we, mmr_in;
    int          delay;
    logic        x_req, x_we, x_mis, x_mmr, x_rd_we, chk_data;
    logic [3:0]  x_be;
    logic [31:0] x_addr, x_wdata, x_rd_data;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic        rd_we, chk_data;
    logic [31:0] rd_data, inst;
  } wb_exp_t;

  wb_exp_t sb_q[$];
  vec_t    vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [2:0] flag, input logic [31:0] addr, sdata, alu,
                              input logic [4:0] rd, input logic rd_we, mmr_in,
                              input logic [31:0] rdata, input int delay,
                              input logic x_req, input logic [3:0] x_be, input logic x_we,
                              input logic [31:0] x_addr, x_wdata, input logic x_mis, x_mmr,
                              input logic [31:0] x_rd_data, input logic x_rd_we, chk_data);
    vec_t v;
    v.flag = flag; v.addr = addr; v.sdata = sdata; v.alu = alu; v.rd = rd; v.rd_we = rd_we;
    v.mmr_in = mmr_in; v.rdata = rdata; v.delay = delay; v.x_req = x_req; v.x_be = x_be;
    v.x_we = x_we; v.x_addr = x_addr; v.x_wdata = x_wdata; v.x_mis = x_mis; v.x_mmr = x_mmr;
    v.x_rd_data = x_rd_data; v.x_rd_we = x_rd_we; v.chk_data = chk_data;
    return v;
  endfunction

  // Scoreboard: every wb_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (wb_valid) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL wb_unexpected: got wb_valid=1 inst=%h expected no retire", wb_inst);
      end else begin
        wb_exp_t e;
        e = sb_q.pop_front();
        chk("wb_rd_addr", 32'(wb_rd_addr), 32'(e.rd));
        chk("wb_rd_we", 32'(wb_rd_we), 32'(e.rd_we));
        chk("wb_inst", wb_inst, e.inst);
        if (e.chk_data) chk("wb_rd_data", wb_rd_data, e.rd_data);
      end
    end
  end

  task automatic drive(input logic [2:0] flag, input logic [31:0] addr, sdata, alu,
                       input logic [4:0] rd, input logic rd_we, mmr_in, input logic [31:0] inst);
    in_valid = 1'b1; mem_flag = flag; mem_addr = addr; store_data = sdata; alu_result = alu;
    rd_addr_in = rd; rd_we_in = rd_we; mmr_we_in = mmr_in; inst_in = inst;
  endtask

  task automatic push(input logic [4:0] rd, input logic rd_we, chk_data,
                      input logic [31:0] data, inst);
    wb_exp_t e;
    e.rd = rd; e.rd_we = rd_we; e.chk_data = chk_data; e.rd_data = data; e.inst = inst;
    sb_q.push_back(e);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] inst;
    inst = 32'hC0DE_0000 | 32'(idx);
    drive(v.flag, v.addr, v.sdata, v.alu, v.rd, v.rd_we, v.mmr_in, inst);
    push(v.rd, v.x_rd_we, v.chk_data, v.x_rd_data, inst);
    tick();
    in_valid = 1'b0;
    chk($sformatf("v%0d_req", idx), 32'(dmem_req), 32'(v.x_req));
    chk($sformatf("v%0d_stall", idx), 32'(stall_out), 32'(v.x_req));
    if (v.x_req) begin
      chk($sformatf("v%0d_be", idx), 32'(dmem_be), 32'(v.x_be));
      chk($sformatf("v%0d_we", idx), 32'(dmem_we), 32'(v.x_we));
      chk($sformatf("v%0d_daddr", idx), dmem_addr, v.x_addr);
      if (v.x_we) chk($sformatf("v%0d_wdata", idx), dmem_wdata, v.x_wdata);
      for (int k = 1; k < v.delay; k++) begin
        tick();
        chk($sformatf("v%0d_req_hold", idx), 32'(dmem_req), 32'd1);
        chk($sformatf("v%0d_stall_hold", idx), 32'(stall_out), 32'd1);
      end
      dmem_rdata = v.rdata;
      dmem_ack   = 1'b1;
      tick();
      dmem_ack = 1'b0;
      chk($sformatf("v%0d_req_drop", idx), 32'(dmem_req), 32'd0);
      chk($sformatf("v%0d_stall_drop", idx), 32'(stall_out), 32'd0);
      chk($sformatf("v%0d_wb_valid", idx), 32'(wb_valid), 32'd1);
      chk($sformatf("v%0d_no_timeout", idx), 32'(err_timeout), 32'd0);
    end else begin
      chk($sformatf("v%0d_wb_valid", idx), 32'(wb_valid), 32'd1);
      chk($sformatf("v%0d_misalign", idx), 32'(err_misalign), 32'(v.x_mis));
      chk($sformatf("v%0d_mmr_we", idx), 32'(mmr_we), 32'(v.x_mmr));
      if (v.x_mmr) begin
        chk($sformatf("v%0d_mmr_addr", idx), mmr_addr, v.x_addr);
        chk($sformatf("v%0d_mmr_wdata", idx), mmr_wdata, v.x_wdata);
      end
      tick();
      chk($sformatf("v%0d_pulse_end", idx), 32'({mmr_we, err_misalign, wb_valid}), 32'd0);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; in_valid = 1'b0; mem_flag = 3'b0; mem_addr = 0; store_data = 0; alu_result = 0;
    rd_addr_in = 0; rd_we_in = 0; mmr_we_in = 0; inst_in = 0; dmem_rdata = 0; dmem_ack = 1'b0;

    //            flag    addr         sdata         alu          rd  we mmr rdata        dly req be    we addr         wdata         mis mmr rd_data       rdwe chk
    vecs[0]  = mk(3'b000, 32'h0,       32'h0,        32'h1234,    5,  1, 0, 32'h0,        0,  0, 4'h0, 0, 32'h0,       32'h0,        0,  0,  32'h1234,     1,   1);
    vecs[1]  = mk(3'b001, 32'h100,     32'h0,        32'h0,       6,  1, 0, 32'hDEADBEEF, 3,  1, 4'hF, 0, 32'h100,     32'h0,        0,  0,  32'hDEADBEEF, 1,   1);
    vecs[2]  = mk(3'b111, 32'h103,     32'h0,        32'h0,       7,  1, 0, 32'h80AA5511, 1,  1, 4'h8, 0, 32'h100,     32'h0,        0,  0,  32'hFFFFFF80, 1,   1);
    vecs[3]  = mk(3'b111, 32'h101,     32'h0,        32'h0,       7,  1, 0, 32'h80AA5511, 2,  1, 4'h2, 0, 32'h100,     32'h0,        0,  0,  32'h00000055, 1,   1);
    vecs[4]  = mk(3'b100, 32'h102,     32'hAB,       32'h0,       8,  1, 0, 32'h0,        2,  1, 4'h4, 1, 32'h100,     32'hABABABAB, 0,  0,  32'h0,        0,   0);
    vecs[5]  = mk(3'b010, 32'h106,     32'h55,       32'h0,       8,  1, 0, 32'h0,        0,  0, 4'h0, 0, 32'h0,       32'h0,        1,  0,  32'h0,        0,   0);
    vecs[6]  = mk(3'b011, 32'h40,      32'h7,        32'h0,       9,  1, 1, 32'h0,        0,  0, 4'h0, 0, 32'h40,      32'h7,        0,  1,  32'h0,        0,   0);
    vecs[7]  = mk(3'b000, 32'h0,       32'h0,        32'h55,      0,  1, 0, 32'h0,        0,  0, 4'h0, 0, 32'h0,       32'h0,        0,  0,  32'h55,       0,   1);
    vecs[8]  = mk(3'b101, 32'h0,       32'h0,        32'hCAFE,    3,  1, 0, 32'h0,        0,  0, 4'h0, 0, 32'h0,       32'h0,        0,  0,  32'hCAFE,     1,   1);
    vecs[9]  = mk(3'b010, 32'h200,     32'h11223344, 32'h0,       4,  1, 0, 32'h0,        2,  1, 4'hF, 1, 32'h200,     32'h11223344, 0,  0,  32'h0,        0,   0);
    vecs[10] = mk(3'b001, 32'h101,     32'h0,        32'h0,       4,  1, 0, 32'h0,        0,  0, 4'h0, 0, 32'h0,       32'h0,        1,  0,  32'h0,        0,   0);
    vecs[11] = mk(3'b111, 32'h100,     32'h0,        32'h0,       10, 1, 0, 32'h000000F0, 1,  1, 4'h1, 0, 32'h100,     32'h0,        0,  0,  32'hFFFFFFF0, 1,   1);
    vecs[12] = mk(3'b111, 32'h102,     32'h0,        32'h0,       10, 1, 0, 32'h80AA5511, 1,  1, 4'h4, 0, 32'h100,     32'h0,        0,  0,  32'hFFFFFFAA, 1,   1);
    vecs[13] = mk(3'b001, 32'h204,     32'h0,        32'h0,       11, 0, 0, 32'h0BADF00D, 1,  1, 4'hF, 0, 32'h204,     32'h0,        0,  0,  32'h0BADF00D, 0,   1);
    vecs[14] = mk(3'b011, 32'h44,      32'h9,        32'h0,       12, 1, 0, 32'h0,        0,  0, 4'h0, 0, 32'h44,      32'h9,        0,  0,  32'h0,        0,   0);

    tick(); tick();
    chk("rst_outputs", 32'({stall_out, dmem_req, dmem_we, dmem_be, mmr_we, wb_valid, wb_rd_we,
                            err_misalign, err_timeout}), 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_wb_data", wb_rd_data, 32'd0);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(vecs[i], i);

    // ack while idle must not start or retire anything
    dmem_ack = 1'b1; tick(); dmem_ack = 1'b0;
    chk("idle_ack_req", 32'(dmem_req), 32'd0);
    tick();

    // in_valid during an access is not accepted
    drive(3'b001, 32'h300, 0, 0, 13, 1, 0, 32'hA0000001);
    push(13, 1, 1, 32'h12345678, 32'hA0000001);
    tick();
    drive(3'b000, 0, 0, 32'h999, 14, 1, 0, 32'hA0000002);
    tick(); tick();
    in_valid = 1'b0;
    chk("busy_stall", 32'(stall_out), 32'd1);
    dmem_rdata = 32'h12345678; dmem_ack = 1'b1; tick(); dmem_ack = 1'b0;
    chk("busy_wb_valid", 32'(wb_valid), 32'd1);
    tick();

    // timeout: no ack at all
    drive(3'b001, 32'h400, 0, 0, 15, 1, 0, 32'hA0000003);
    push(15, 0, 0, 32'h0, 32'hA0000003);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (dmem_req && n < 20) begin
      n++;
      tick();
    end
    chk("to_req_cycles", 32'(n), 32'd4);
    chk("to_err_pulse", 32'(err_timeout), 32'd1);
    chk("to_wb_valid", 32'(wb_valid), 32'd1);
    chk("to_stall", 32'(stall_out), 32'd0);
    tick();
    chk("to_pulse_end", 32'(err_timeout), 32'd0);

    // ack on the limit cycle wins over timeout
    drive(3'b001, 32'h500, 0, 0, 16, 1, 0, 32'hA0000004);
    push(16, 1, 1, 32'h5A5A0001, 32'hA0000004);
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("lim_req_still", 32'(dmem_req), 32'd1);
    dmem_rdata = 32'h5A5A0001; dmem_ack = 1'b1; tick(); dmem_ack = 1'b0;
    chk("lim_no_timeout", 32'(err_timeout), 32'd0);
    chk("lim_req_drop", 32'(dmem_req), 32'd0);
    tick();

    // reset on the second request cycle discards the access
    drive(3'b001, 32'h600, 0, 0, 17, 1, 0, 32'hA0000005);
    tick();
    in_valid = 1'b0;
    tick();
    chk("rmid_req_before", 32'(dmem_req), 32'd1);
    reset = 1'b1;
    tick();
    chk("rmid_req", 32'(dmem_req), 32'd0);
    chk("rmid_stall", 32'(stall_out), 32'd0);
    chk("rmid_wb_valid", 32'(wb_valid), 32'd0);
    reset = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF0000; tick(); dmem_ack = 1'b0;
    chk("rmid_late_ack", 32'(wb_valid), 32'd0);
    tick();

    drive(3'b000, 0, 0, 32'h777, 18, 1, 0, 32'hA0000006);
    push(18, 1, 1, 32'h777, 32'hA0000006);
    tick();
    in_valid = 1'b0;
    chk("post_rst_wb", 32'(wb_valid), 32'd1);
    tick(); tick();

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1);
  end

endmodule
